// File: rtl/serial_negate_unit.sv
// ---------------------------------------------------------------------------
// serial_negate_unit
//
// Digit-serial pass / negate / abs / negative-abs unit. The operand is walked
// from the LSB upward DIGIT bits per clock through a small (DIGIT+1)-bit adder
// slice. A negation is formed as (~x + 1): the operand digits are inverted and
// the "+1" enters as the initial carry. A start/busy/done handshake lets a
// sequencer share the slice across operations.
//
// Parameters:
//   W      operand/result width (>= 2)
//   DIGIT  bits processed per clock; W must be a multiple of DIGIT
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   start     in   operation request, sampled only in IDLE
//   mode      in   00 pass, 01 -x, 10 |x|, 11 -|x| (sampled with start)
//   in_data   in   W-bit signed operand (sampled with start)
//   busy      out  high while the digit loop is running
//   done      out  one-cycle completion pulse
//   out_data  out  result, held until the next completion
//   ovf       out  most-negative value had to be negated; held with out_data
//
// Build option:
//   NEG_SAT_EN  when defined, an overflowing result saturates to the
//               most-positive value instead of wrapping.
// ---------------------------------------------------------------------------
module serial_negate_unit #(
  parameter int W     = 6,
  parameter int DIGIT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [W-1:0] in_data,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] out_data,
  output logic         ovf
);

  localparam int NDIG = W / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  MOST_POS = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  op_q, op_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [W-1:0]  res_q, res_d;
  logic [1:0]    mode_q, mode_d;
  logic          inv_q, inv_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  out_q, out_d;
  logic          ovf_q, ovf_d;

  // Datapath slice: current digit (optionally inverted) plus carry. The new
  // digit enters the result register at the top so that after NDIG steps the
  // first digit processed has reached the LSB position.
  logic [DIGIT-1:0] digit_x;
  logic [DIGIT:0]   sum;
  logic [W-1:0]     res_next;
  logic             ovf_next;
  logic             start_inv;

  assign digit_x  = inv_q ? ~sh_q[DIGIT-1:0] : sh_q[DIGIT-1:0];
  assign sum      = {1'b0, digit_x} + {{DIGIT{1'b0}}, carry_q};
  assign res_next = W'({sum[DIGIT-1:0], res_q} >> DIGIT);

  // Only the most-negative operand overflows, and only when it is actually
  // inverted; -|x| of it never inverts because the value is already negative.
  assign ovf_next = inv_q && (op_q == MOST_NEG) &&
                    ((mode_q == 2'b01) || (mode_q == 2'b10));

  assign start_inv = (mode == 2'b01) ||
                     ((mode == 2'b10) &&  in_data[W-1]) ||
                     ((mode == 2'b11) && !in_data[W-1]);

  // Next-state and next-output computation for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sh_d    = sh_q;
    res_d   = res_q;
    mode_d  = mode_q;
    inv_d   = inv_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    out_d   = out_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = in_data;
          sh_d    = in_data;
          mode_d  = mode;
          inv_d   = start_inv;
          carry_d = start_inv;
          cnt_d   = '0;
          res_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_next;
        carry_d = sum[DIGIT];
        sh_d    = sh_q >> DIGIT;
        if (cnt_q == LAST) begin
          // Final digit: publish the result on this same edge; the carry out
          // of the top digit is simply dropped.
          state_d = DONE;
          done_d  = 1'b1;
          ovf_d   = ovf_next;
`ifdef NEG_SAT_EN
          out_d   = ovf_next ? MOST_POS : res_next;
`else
          out_d   = res_next;
`endif
        end else begin
          cnt_d  = cnt_q + CW'(1);
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state and outputs are registered; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      sh_q    <= '0;
      res_q   <= '0;
      mode_q  <= '0;
      inv_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      mode_q  <= mode_d;
      inv_q   <= inv_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out_data = out_q;
  assign ovf      = ovf_q;

endmodule

// File: doc/serial_negate_unit.md
Name: serial_negate_unit

Overview:
Parametrised, digit-serial successor to the combinational 6-bit negation block in the Basys3 ALU. It computes pass, two's-complement negate, absolute value or negative-absolute of a W-bit operand, DIGIT bits per clock. A start/busy/done handshake lets the ALU sequencer share one small adder slice across widths. It flags overflow when the most-negative value would have to be negated.

Parameters:
W, 6, operand/result width in bits; must be at least 2.
DIGIT, 1, bits processed per clock; W must be an integer multiple of DIGIT. NDIG = W/DIGIT.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
mode  input  2  00 pass, 01 negate (-x), 10 abs (|x|), 11 negative-abs (-|x|); sampled with start.
in_data  input  W  signed two's-complement operand; sampled with start.
busy  output  1  high while state is RUN.
done  output  1  one-cycle completion pulse.
out_data  output  W  result; held from DONE until the next DONE.
ovf  output  1  overflow flag for the last result; held with out_data.

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, out_data=0, ovf=0; internal operand, count, carry and mode registers cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: on a clock edge with start=1:
  - latch in_data and mode;
  - compute inv = (mode==01) | (mode==10 & in_data[W-1]) | (mode==11 & ~in_data[W-1]);
  - carry=inv, count=0, go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge processes digit[count] from the LSB upward:
  - r = (inv ? ~digit : digit) + carry, computed DIGIT+1 bits wide;
  - low DIGIT bits go into the result shift register; carry = bit DIGIT of r.
  - After the edge processing count==NDIG-1: go to DONE, load out_data and ovf on that same edge.
- DONE: done=1 for exactly one cycle, busy=0; next edge goes to IDLE.
- Latency: done is high in the cycle beginning NDIG edges after the edge that sampled start. Next start is accepted in the cycle after done; throughput is one op per NDIG+2 cycles.
- start while busy or in DONE: ignored, no queuing. mode and in_data changes after the sampling edge have no effect.
- ovf = inv & (operand == 1 followed by W-1 zeros). It can be set only in modes 01/10; mode 11 never overflows. The wrapped result equals the operand (e.g. 100000).
- Final carry-out is discarded; negating 0 yields 0 with ovf=0.
- Reset mid-RUN: immediately returns to IDLE with all outputs 0. The partial result is lost and no done pulse is generated.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
Macro NEG_SAT_EN.
- Defined: when ovf is set, out_data is saturated to the most-positive value (0 followed by W-1 ones); ovf is still asserted.
- Undefined: the wrapped result is output (equal to the operand); ovf is asserted. Latency is identical in both builds.

Test Plan:
- W=6, DIGIT=1, mode=01, in_data=010101: done 6 edges after start; out_data=101011, ovf=0; busy high exactly 6 cycles.
- mode=10, in_data=111000 -> 001000, ovf=0; mode=10, in_data=011011 -> 011011 (pass-through path).
- mode=01, in_data=100000 -> out_data=100000, ovf=1; with NEG_SAT_EN -> 011111, ovf=1. mode=11 with the same input -> 100000, ovf=0.
- mode=01, in_data=000000 -> 000000, ovf=0. mode=11, in_data=011111 -> 100001. mode=00, in_data=011110 -> 011110.
- Pulse start again 2 cycles into RUN with different data: ignored, first result unchanged. Assert reset at cycle 3 of RUN: outputs 0 at once, no done pulse. A fresh start after reset completes normally.
- W=8, DIGIT=2, mode=01, in_data=8'h01: done 4 edges after start, out_data=8'hFF. Back-to-back starts issued the cycle after each done all complete.
